// File: rtl/seven_seg_mux_if.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_mux_if
//  Description : Bundles the value, decimal-point, blanking and mode inputs
//                with the registered digit-enable, segment and frame outputs
//                of the seven_seg_mux display driver.
//                  DATA    [4*N_DIGITS] digit values, digit 0 rightmost
//                  DP      [N_DIGITS]   decimal point request, active-high
//                  BLANK   [N_DIGITS]   force digit dark, active-high
//                  HEX     [1]          render 10..15 as A..F
//                  LZ_EN   [1]          leading-zero suppression enable
//                  DIGIT   [N_DIGITS]   digit enables, active-low one-hot
//                  DISPLAY [8]          {a,b,c,d,e,f,g,dp}, active-low
//                  FRAME   [1]          pulse when digit 0 becomes active
//                master : value source side; slave : the display driver.
//  Revision    : 1.0  initial release
// ============================================================================
interface seven_seg_mux_if #(
    parameter int N_DIGITS = 4
);
    logic [4*N_DIGITS-1:0] DATA;
    logic [N_DIGITS-1:0]   DP;
    logic [N_DIGITS-1:0]   BLANK;
    logic                  HEX;
    logic                  LZ_EN;
    logic [N_DIGITS-1:0]   DIGIT;
    logic [7:0]            DISPLAY;
    logic                  FRAME;

    modport master (
        output DATA, DP, BLANK, HEX, LZ_EN,
        input  DIGIT, DISPLAY, FRAME
    );

    modport slave (
        input  DATA, DP, BLANK, HEX, LZ_EN,
        output DIGIT, DISPLAY, FRAME
    );
endinterface
`default_nettype wire

// File: rtl/seven_seg_mux.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_mux
//  Description : N-digit multiplexed seven-segment driver for a common-anode
//                display. Each digit stays lit for REFRESH_DIV clocks; the
//                scan runs digit 0 (rightmost) upward and wraps. All inputs
//                are snapshotted at the start of every frame so a frame never
//                mixes old and new values. Supports hex rendering, per-digit
//                decimal point and blanking, and leading-zero suppression.
//  Ports       : clk  - system clock, rising edge
//                rst  - synchronous active-high reset, display dark
//                bus  - seven_seg_mux_if.slave (values in, DIGIT/DISPLAY/
//                       FRAME out; outputs are registered, active-low)
//  Revision    : 1.0  initial release
// ============================================================================
module seven_seg_mux #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = 16
) (
    input  wire logic       clk,
    input  wire logic       rst,
    seven_seg_mux_if.slave  bus
);

    localparam int                 c_IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0]   c_CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(N_DIGITS - 1);

    // Refresh / scan state
    logic [CNT_W-1:0]      r_cnt;
    logic [c_IDX_W-1:0]    r_idx;

    // Frame snapshot
    logic [4*N_DIGITS-1:0] r_data;
    logic [N_DIGITS-1:0]   r_dp;
    logic [N_DIGITS-1:0]   r_blank;
    logic                  r_hex;
    logic                  r_lz;

    // Registered outputs
    logic [N_DIGITS-1:0]   r_digit;
    logic [7:0]            r_display;
    logic                  r_frame;

    logic                  w_tick;
    logic [c_IDX_W-1:0]    w_next_idx;
    logic                  w_frame_start;
    logic [4*N_DIGITS-1:0] w_data;
    logic [N_DIGITS-1:0]   w_dp;
    logic [N_DIGITS-1:0]   w_blank;
    logic                  w_hex;
    logic                  w_lz;
    logic [3:0]            w_val;
    logic                  w_dp_sel;
    logic                  w_blank_sel;
    logic                  w_upper_nz;
    logic                  w_suppress;
    logic [7:0]            w_code;

    // Active-low {a,b,c,d,e,f,g}
    function automatic logic [6:0] seg_code(input logic [3:0] v, input logic hex);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        if (!hex && (v > 4'd9)) begin
            s = 7'b1111111;
        end
        return s;
    endfunction

    assign w_tick        = (r_cnt == c_CNT_LAST);
    assign w_next_idx    = (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
    assign w_frame_start = w_tick && (w_next_idx == '0);

    // On a frame-start tick digit 0 is rendered from the live inputs, which
    // are exactly what the snapshot captures on that same edge.
    assign w_data  = w_frame_start ? bus.DATA  : r_data;
    assign w_dp    = w_frame_start ? bus.DP    : r_dp;
    assign w_blank = w_frame_start ? bus.BLANK : r_blank;
    assign w_hex   = w_frame_start ? bus.HEX   : r_hex;
    assign w_lz    = w_frame_start ? bus.LZ_EN : r_lz;

    // Select the next digit's fields and look for any nonzero value at or
    // above it; if none, the digit is part of the leading-zero run.
    always_comb begin
        w_val       = 4'h0;
        w_dp_sel    = 1'b0;
        w_blank_sel = 1'b0;
        w_upper_nz  = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (c_IDX_W'(k) == w_next_idx) begin
                w_val       = w_data[4*k +: 4];
                w_dp_sel    = w_dp[k];
                w_blank_sel = w_blank[k];
            end
            if ((c_IDX_W'(k) >= w_next_idx) && (w_data[4*k +: 4] != 4'h0)) begin
                w_upper_nz = 1'b1;
            end
        end
    end

    // Digit 0 is never suppressed so a zero value still shows "0".
    assign w_suppress = w_lz && (w_next_idx != '0) && !w_upper_nz;

    assign w_code = (w_blank_sel || w_suppress) ? 8'hFF
                                                : {seg_code(w_val, w_hex), ~w_dp_sel};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_idx     <= c_IDX_LAST;
            r_data    <= '0;
            r_dp      <= '0;
            r_blank   <= '0;
            r_hex     <= 1'b0;
            r_lz      <= 1'b0;
            r_digit   <= '1;
            r_display <= 8'hFF;
            r_frame   <= 1'b0;
        end else begin
            r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
            r_frame <= w_frame_start;
            if (w_tick) begin
                r_idx     <= w_next_idx;
                r_digit   <= ~(N_DIGITS'(1) << w_next_idx);
                r_display <= w_code;
            end
            if (w_frame_start) begin
                r_data  <= bus.DATA;
                r_dp    <= bus.DP;
                r_blank <= bus.BLANK;
                r_hex   <= bus.HEX;
                r_lz    <= bus.LZ_EN;
            end
        end
    end

    assign bus.DIGIT   = r_digit;
    assign bus.DISPLAY = r_display;
    assign bus.FRAME   = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_seg_mux
//  Description : Self-checking bench for seven_seg_mux (4 digits, 4-clock
//                dwell). Expected outputs are pushed to a scoreboard when
//                stimulus is applied and popped at each tick.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seven_seg_mux;

    localparam int c_N  = 4;
    localparam int c_RD = 4;
    localparam int c_CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seven_seg_mux_if #(.N_DIGITS(c_N)) bus ();

    seven_seg_mux #(
        .N_DIGITS    (c_N),
        .REFRESH_DIV (c_RD),
        .CNT_W       (c_CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] digit;
        logic [7:0] disp;
        logic       frame;
    } exp_t;

    // disp[k] is the expected DISPLAY while digit k is lit
    typedef struct {
        string           name;
        logic [15:0]     data;
        logic [3:0]      dp;
        logic [3:0]      blank;
        logic            hex;
        logic            lz;
        logic [3:0][7:0] disp;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[10];
    int   total = 0;
    int   bad   = 0;

    task automatic push(input string nm, input logic [3:0] d, input logic [7:0] s, input logic f);
        exp_t e;
        e.name  = nm;
        e.digit = d;
        e.disp  = s;
        e.frame = f;
        sbq.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty: got digit=%b display=%b frame=%b, nothing expected",
                     bus.DIGIT, bus.DISPLAY, bus.FRAME);
        end else begin
            e = sbq.pop_front();
            if (bus.DIGIT !== e.digit || bus.DISPLAY !== e.disp || bus.FRAME !== e.frame) begin
                bad++;
                $display("FAIL %s: got digit=%b display=%b frame=%b, want digit=%b display=%b frame=%b",
                         e.name, bus.DIGIT, bus.DISPLAY, bus.FRAME, e.digit, e.disp, e.frame);
            end
        end
    endtask

    // Advance n rising edges and sample 1 ns later
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string nm, input logic [3:0] d, input logic [7:0] s, input logic f);
        push(nm, d, s, f);
        check_pop();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Expected codes per digit: {d3, d2, d1, d0}
        vecs[0] = '{"hex0_lz",      16'h00A0, 4'b0000, 4'b0000, 1'b0, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'h03}};
        vecs[1] = '{"hex1_lz",      16'h00A0, 4'b0000, 4'b0000, 1'b1, 1'b1, {8'hFF, 8'hFF, 8'h11, 8'h03}};
        vecs[2] = '{"dp0_lz",       16'h0005, 4'b0001, 4'b0000, 1'b0, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'h48}};
        vecs[3] = '{"blank0",       16'h0005, 4'b0001, 4'b0001, 1'b0, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hFF}};
        vecs[4] = '{"all_zero_lz",  16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'h03}};
        vecs[5] = '{"all_zero_nlz", 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b0, {8'h03, 8'h03, 8'h03, 8'h03}};
        vecs[6] = '{"inner_zero",   16'h0F0F, 4'b0000, 4'b0000, 1'b1, 1'b1, {8'hFF, 8'h71, 8'h03, 8'h71}};
        vecs[7] = '{"dp_mix",       16'h1000, 4'b1010, 4'b0000, 1'b0, 1'b1, {8'h9E, 8'h03, 8'h02, 8'h03}};
        vecs[8] = '{"hex_letters",  16'hBCDE, 4'b0000, 4'b0000, 1'b1, 1'b0, {8'hC1, 8'h63, 8'h85, 8'h61}};
        vecs[9] = '{"dp_on_lz",     16'h0050, 4'b1000, 4'b0000, 1'b0, 1'b1, {8'hFF, 8'hFF, 8'h49, 8'h03}};

        bus.DATA  = 16'h1234;
        bus.DP    = 4'b0000;
        bus.BLANK = 4'b0000;
        bus.HEX   = 1'b0;
        bus.LZ_EN = 1'b0;
        rst       = 1'b1;

        // Reset and first light
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            expect_now("rst_dark", 4'b1111, 8'hFF, 1'b0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            expect_now("pre_light", 4'b1111, 8'hFF, 1'b0);
        end
        cyc(1);
        expect_now("first_light", 4'b1110, 8'h99, 1'b1);
        cyc(1);
        expect_now("frame_drop", 4'b1110, 8'h99, 1'b0);

        // Scan order and wrap
        cyc(c_RD - 1);
        expect_now("scan_d1", 4'b1101, 8'h0D, 1'b0);
        cyc(2);
        expect_now("hold_d1", 4'b1101, 8'h0D, 1'b0);
        cyc(c_RD - 2);
        expect_now("scan_d2", 4'b1011, 8'h25, 1'b0);
        cyc(c_RD);
        expect_now("scan_d3", 4'b0111, 8'h9F, 1'b0);
        cyc(c_RD);
        expect_now("wrap_d0", 4'b1110, 8'h99, 1'b1);

        // Snapshot: change DATA while digit 1 is lit
        cyc(c_RD);
        expect_now("snap_d1", 4'b1101, 8'h0D, 1'b0);
        bus.DATA = 16'h9999;
        push("snap_old_d2", 4'b1011, 8'h25, 1'b0);
        push("snap_old_d3", 4'b0111, 8'h9F, 1'b0);
        push("snap_new_d0", 4'b1110, 8'h09, 1'b1);
        push("snap_new_d1", 4'b1101, 8'h09, 1'b0);
        push("snap_new_d2", 4'b1011, 8'h09, 1'b0);
        push("snap_new_d3", 4'b0111, 8'h09, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cyc(c_RD);
            check_pop();
        end

        // Table vectors: applied while digit 3 is lit, checked over the next frame
        for (int v = 0; v < 10; v++) begin
            bus.DATA  = vecs[v].data;
            bus.DP    = vecs[v].dp;
            bus.BLANK = vecs[v].blank;
            bus.HEX   = vecs[v].hex;
            bus.LZ_EN = vecs[v].lz;
            for (int k = 0; k < c_N; k++) begin
                logic [3:0] one;
                one = 4'b0001 << k;
                push($sformatf("%s_d%0d", vecs[v].name, k), ~one, vecs[v].disp[k], (k == 0));
            end
            for (int k = 0; k < c_N; k++) begin
                cyc(c_RD);
                check_pop();
            end
        end

        // Mid-scan reset while digit 2 is lit
        bus.DATA  = 16'h1234;
        bus.DP    = 4'b0000;
        bus.BLANK = 4'b0000;
        bus.HEX   = 1'b0;
        bus.LZ_EN = 1'b0;
        cyc(c_RD);
        expect_now("pre_rst_d0", 4'b1110, 8'h99, 1'b1);
        cyc(c_RD);
        expect_now("pre_rst_d1", 4'b1101, 8'h0D, 1'b0);
        cyc(c_RD);
        expect_now("pre_rst_d2", 4'b1011, 8'h25, 1'b0);
        cyc(1);
        rst = 1'b1;
        cyc(1);
        expect_now("midscan_rst", 4'b1111, 8'hFF, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            expect_now("restart_dark", 4'b1111, 8'hFF, 1'b0);
        end
        cyc(1);
        expect_now("restart_light", 4'b1110, 8'h99, 1'b1);
        cyc(c_RD);
        expect_now("restart_d1", 4'b1101, 8'h0D, 1'b0);

        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover: got %0d pending, want 0", sbq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
